// File: rtl/jt201d_cmd_pkg.sv
// Shared definitions for the jt201D UART command parser: frame characters,
// parser states and the ASCII hex digit decoder.
package jt201d_cmd_pkg;

    localparam logic [7:0] CH_LBRACE = 8'h7B;
    localparam logic [7:0] CH_RBRACE = 8'h7D;
    localparam logic [7:0] CH_COLON  = 8'h3A;
    localparam logic [7:0] CH_OP_WR  = 8'h61;
    localparam logic [7:0] CH_OP_RD  = 8'h41;

    typedef enum logic [2:0] {
        IDLE,
        OP,
        SEP1,
        ADDR,
        SEP2,
        DATA,
        CLOSE,
        ISSUE
    } parser_state_e;

    // Returns {valid, nibble}; letters a-f are accepted in either case.
    function automatic logic [4:0] hex_to_nibble(input logic [7:0] ch);
        logic [4:0] res;
        res = 5'b0;
        if (ch >= 8'h30 && ch <= 8'h39) begin
            res = {1'b1, ch[3:0]};
        end else if ((ch >= 8'h41 && ch <= 8'h46) || (ch >= 8'h61 && ch <= 8'h66)) begin
            res = {1'b1, ch[3:0] + 4'd9};
        end
        return res;
    endfunction

endpackage

// File: rtl/uart_cmd_parser.sv
// Turns the ASCII frame stream {op:AAA:DDDDD} from the UART receiver into one
// held SPI register request on a valid/ready handshake.
module uart_cmd_parser
    import jt201d_cmd_pkg::*;
#(
    parameter int ADDR_DIGITS = 3,
    parameter int DATA_DIGITS = 5,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                     i_clk_sys,
    input  logic                     i_rst_n,
    input  logic [7:0]               i_rx_data,
    input  logic                     i_rx_valid,
    input  logic                     i_rx_err,
    output logic                     o_req_valid,
    input  logic                     i_req_ready,
    output logic                     o_req_wr,
    output logic [4*ADDR_DIGITS-1:0] o_req_addr,
    output logic [4*DATA_DIGITS-1:0] o_req_wdata,
    output logic                     o_err,
    output logic                     o_overrun
);

    localparam int ADDR_W  = 4 * ADDR_DIGITS;
    localparam int DATA_W  = 4 * DATA_DIGITS;
    localparam int MAX_DIG = (ADDR_DIGITS > DATA_DIGITS) ? ADDR_DIGITS : DATA_DIGITS;
    localparam int DIG_W   = $clog2(MAX_DIG + 1);
    localparam int TMO_W   = $clog2(TIMEOUT_CYC + 1);

    parser_state_e state, state_next;

    logic [DIG_W-1:0] dig_cnt;
    logic [TMO_W-1:0] tmo_cnt;
    logic [4:0]       hex;
    logic             parsing;
    logic             timeout_hit;
    logic             bad_byte;
    logic             err_next;
    logic             ovr_next;
    logic             addr_shift;
    logic             data_shift;
    logic             wr_load;
    logic             wr_val;
    logic             dig_clr;
    logic             dig_inc;

    assign hex         = hex_to_nibble(i_rx_data);
    assign parsing     = (state != IDLE) && (state != ISSUE);
    assign timeout_hit = parsing && (tmo_cnt == TMO_W'(TIMEOUT_CYC));

    // State register.
    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; rx errors beat bytes, bytes beat the timeout.
    always_comb begin
        state_next = state;
        err_next   = 1'b0;
        ovr_next   = 1'b0;
        addr_shift = 1'b0;
        data_shift = 1'b0;
        wr_load    = 1'b0;
        wr_val     = 1'b0;
        dig_clr    = 1'b0;
        dig_inc    = 1'b0;
        bad_byte   = 1'b0;
        case (state)
            IDLE: begin
                if (i_rx_valid && !i_rx_err && i_rx_data == CH_LBRACE) begin
                    state_next = OP;
                end
            end
            ISSUE: begin
                if (i_rx_valid) begin
                    ovr_next = 1'b1;
                end
                if (o_req_valid && i_req_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                if (i_rx_err) begin
                    err_next   = 1'b1;
                    state_next = IDLE;
                end else if (i_rx_valid) begin
                    if (i_rx_data == CH_LBRACE) begin
                        err_next   = 1'b1;
                        state_next = OP;
                    end else begin
                        case (state)
                            OP: begin
                                if (i_rx_data == CH_OP_WR || i_rx_data == CH_OP_RD) begin
                                    wr_load    = 1'b1;
                                    wr_val     = (i_rx_data == CH_OP_WR);
                                    state_next = SEP1;
                                end else begin
                                    bad_byte = 1'b1;
                                end
                            end
                            SEP1: begin
                                if (i_rx_data == CH_COLON) begin
                                    dig_clr    = 1'b1;
                                    state_next = ADDR;
                                end else begin
                                    bad_byte = 1'b1;
                                end
                            end
                            ADDR: begin
                                if (hex[4]) begin
                                    addr_shift = 1'b1;
                                    if (dig_cnt == DIG_W'(ADDR_DIGITS - 1)) begin
                                        state_next = SEP2;
                                    end else begin
                                        dig_inc = 1'b1;
                                    end
                                end else begin
                                    bad_byte = 1'b1;
                                end
                            end
                            SEP2: begin
                                if (i_rx_data == CH_COLON) begin
                                    dig_clr    = 1'b1;
                                    state_next = DATA;
                                end else begin
                                    bad_byte = 1'b1;
                                end
                            end
                            DATA: begin
                                if (hex[4]) begin
                                    data_shift = 1'b1;
                                    if (dig_cnt == DIG_W'(DATA_DIGITS - 1)) begin
                                        state_next = CLOSE;
                                    end else begin
                                        dig_inc = 1'b1;
                                    end
                                end else begin
                                    bad_byte = 1'b1;
                                end
                            end
                            CLOSE: begin
                                if (i_rx_data == CH_RBRACE) begin
                                    state_next = ISSUE;
                                end else begin
                                    bad_byte = 1'b1;
                                end
                            end
                            default: begin
                                bad_byte = 1'b1;
                            end
                        endcase
                        if (bad_byte) begin
                            err_next   = 1'b1;
                            state_next = IDLE;
                        end
                    end
                end else if (timeout_hit) begin
                    err_next   = 1'b1;
                    state_next = IDLE;
                end
            end
        endcase
    end

    // Inter-byte timeout; any incoming byte or rx error restarts the count.
    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tmo_cnt <= '0;
        end else if (!parsing || i_rx_valid || i_rx_err) begin
            tmo_cnt <= '0;
        end else if (tmo_cnt != TMO_W'(TIMEOUT_CYC)) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end

    // Digit counter for the address and data fields.
    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            dig_cnt <= '0;
        end else if (dig_clr) begin
            dig_cnt <= '0;
        end else if (dig_inc) begin
            dig_cnt <= dig_cnt + DIG_W'(1);
        end
    end

    // Request fields shift in place; they only move while no request is held.
    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_req_wr    <= 1'b0;
            o_req_addr  <= '0;
            o_req_wdata <= '0;
        end else begin
            if (wr_load) begin
                o_req_wr <= wr_val;
            end
            if (addr_shift) begin
                o_req_addr <= (o_req_addr << 4) | ADDR_W'(hex[3:0]);
            end
            if (data_shift) begin
                o_req_wdata <= (o_req_wdata << 4) | DATA_W'(hex[3:0]);
            end
        end
    end

    // Registered handshake valid and single-cycle status pulses.
    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_req_valid <= 1'b0;
            o_err       <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            o_req_valid <= (state_next == ISSUE);
            o_err       <= err_next;
            o_overrun   <= ovr_next;
        end
    end

endmodule
